// File: rtl/threshold_binarizer.sv
// ---------------------------------------------------------------------------
// threshold_binarizer
//
// Purpose:
//   Turns a grayscale pixel stream into a 1-bit foreground/background stream.
//   It uses a per-frame threshold supplied by the upstream histogram stage.
//   A new threshold is only adopted at a frame start, so every pixel of one
//   frame is compared against the same value. The block also counts the
//   foreground pixels of each frame and reports the total when the frame ends.
//
// Ports:
//   iClk            clock
//   iRst_n          asynchronous active-low reset
//   iGray           input pixel (DATA_W bits)
//   iGrayValid      pixel qualifier
//   iFvalid         frame valid, high for the whole frame
//   iThresh         threshold from the histogram stage
//   iThreshValid    one-cycle pulse marking iThresh as valid
//   oBin            binarised pixel, 2 cycles after input
//   oBinValid       oBin qualifier
//   oFvalid         iFvalid aligned with oBin
//   oGray           iGray aligned with oBin
//   oFgCount        foreground count of the last completed frame
//   oCountValid     one-cycle pulse when oFgCount updates
//   oActiveThresh   threshold applied to the current frame
//   oThreshPending  a new threshold waits for the next frame start
// ---------------------------------------------------------------------------
module threshold_binarizer #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned COUNT_W        = 20,
    parameter int unsigned DEFAULT_THRESH = 128,
    parameter bit          FG_ABOVE       = 1'b1
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic [DATA_W-1:0]  iGray,
    input  logic               iGrayValid,
    input  logic               iFvalid,
    input  logic [DATA_W-1:0]  iThresh,
    input  logic               iThreshValid,
    output logic               oBin,
    output logic               oBinValid,
    output logic               oFvalid,
    output logic [DATA_W-1:0]  oGray,
    output logic [COUNT_W-1:0] oFgCount,
    output logic               oCountValid,
    output logic [DATA_W-1:0]  oActiveThresh,
    output logic               oThreshPending
);

    localparam logic [DATA_W-1:0]  RESET_THRESH = DATA_W'(DEFAULT_THRESH);
    localparam logic [COUNT_W-1:0] COUNT_MAX    = {COUNT_W{1'b1}};

    // Frame tracking and threshold bookkeeping
    logic              fvPrev_q;
    logic              lowSeen_q;
    logic              armed_q;
    logic              pendFlag_q,     pendFlag_d;
    logic [DATA_W-1:0] pendThresh_q,   pendThresh_d;
    logic [DATA_W-1:0] activeThresh_q, activeThresh_d;

    logic              rise;
    logic              armedEff;
    logic              accept;
    logic [DATA_W-1:0] startThresh;
    logic [DATA_W-1:0] effThresh;

    // Pipeline stage 1
    logic              acc1_q;
    logic              fv1_q;
    logic [DATA_W-1:0] gray1_q;
    logic [DATA_W-1:0] thr1_q;

    // Pipeline stage 2 (the visible outputs)
    logic              cmpHit;
    logic              bin_q;
    logic              binValid_q;
    logic              fv2_q;
    logic [DATA_W-1:0] gray2_q;

    // Foreground counting
    logic               fvOutPrev_q;
    logic               frameEnd;
    logic               fgInc;
    logic [COUNT_W-1:0] cntNext;
    logic [COUNT_W-1:0] cnt_q,        cnt_d;
    logic [COUNT_W-1:0] fgCount_q,    fgCount_d;
    logic               countValid_q, countValid_d;

    // Detect a frame start and decide which threshold the starting frame uses.
    // lowSeen_q masks the rising edge until iFvalid has been seen low once
    // after reset. A frame already in flight when reset releases therefore
    // does not count as a start and is skipped entirely. The cost is that a
    // frame can begin at the earliest one cycle after reset release.
    // A threshold pulse on the start cycle takes priority over a pending one,
    // because it is the newest value. Otherwise a pending threshold is
    // promoted. Outside a frame start the active threshold never moves, so it
    // stays constant while iFvalid is high.
    always_comb begin
        rise           = iFvalid & ~fvPrev_q & lowSeen_q;
        armedEff       = armed_q | rise;
        accept         = iGrayValid & iFvalid & armedEff;
        startThresh    = activeThresh_q;
        if (iThreshValid) begin
            startThresh = iThresh;
        end else if (pendFlag_q) begin
            startThresh = pendThresh_q;
        end
        effThresh      = rise ? startThresh : activeThresh_q;
        activeThresh_d = effThresh;
        pendFlag_d     = pendFlag_q;
        pendThresh_d   = pendThresh_q;
        if (rise) begin
            pendFlag_d = 1'b0;
        end else if (iThreshValid) begin
            pendFlag_d   = 1'b1;
            pendThresh_d = iThresh;
        end
    end

    // Register the frame-tracking and threshold state. Once armed, the block
    // stays armed until the next reset.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            fvPrev_q       <= 1'b0;
            lowSeen_q      <= 1'b0;
            armed_q        <= 1'b0;
            pendFlag_q     <= 1'b0;
            pendThresh_q   <= '0;
            activeThresh_q <= RESET_THRESH;
        end else begin
            fvPrev_q       <= iFvalid;
            lowSeen_q      <= lowSeen_q | ~iFvalid;
            armed_q        <= armedEff;
            pendFlag_q     <= pendFlag_d;
            pendThresh_q   <= pendThresh_d;
            activeThresh_q <= activeThresh_d;
        end
    end

    // Stage 1 captures the pixel with the threshold it must be judged against.
    // The frame-valid copy is masked while unarmed, so a skipped frame never
    // produces a frame end downstream.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            acc1_q  <= 1'b0;
            fv1_q   <= 1'b0;
            gray1_q <= '0;
            thr1_q  <= '0;
        end else begin
            acc1_q  <= accept;
            fv1_q   <= iFvalid & armedEff;
            gray1_q <= iGray;
            thr1_q  <= effThresh;
        end
    end

    // The comparison polarity is chosen at elaboration. The compare is unsigned.
    always_comb begin
        cmpHit = FG_ABOVE ? (gray1_q > thr1_q) : (gray1_q <= thr1_q);
    end

    // Stage 2 produces the output pixel. oBin is forced low for rejected pixels.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            bin_q      <= 1'b0;
            binValid_q <= 1'b0;
            fv2_q      <= 1'b0;
            gray2_q    <= '0;
        end else begin
            bin_q      <= acc1_q & cmpHit;
            binValid_q <= acc1_q;
            fv2_q      <= fv1_q;
            gray2_q    <= gray1_q;
        end
    end

    // A frame ends on the falling edge of the output-aligned frame valid.
    // The count reported at frame end includes any increment from that same
    // cycle. The counter saturates instead of wrapping.
    always_comb begin
        frameEnd     = fvOutPrev_q & ~fv2_q;
        fgInc        = binValid_q & bin_q;
        cntNext      = cnt_q;
        if (fgInc && (cnt_q != COUNT_MAX)) begin
            cntNext = cnt_q + 1'b1;
        end
        cnt_d        = frameEnd ? '0 : cntNext;
        fgCount_d    = frameEnd ? cntNext : fgCount_q;
        countValid_d = frameEnd;
    end

    // Register the counter and the per-frame result.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            fvOutPrev_q  <= 1'b0;
            cnt_q        <= '0;
            fgCount_q    <= '0;
            countValid_q <= 1'b0;
        end else begin
            fvOutPrev_q  <= fv2_q;
            cnt_q        <= cnt_d;
            fgCount_q    <= fgCount_d;
            countValid_q <= countValid_d;
        end
    end

    assign oBin           = bin_q;
    assign oBinValid      = binValid_q;
    assign oFvalid        = fv2_q;
    assign oGray          = gray2_q;
    assign oFgCount       = fgCount_q;
    assign oCountValid    = countValid_q;
    assign oActiveThresh  = activeThresh_q;
    assign oThreshPending = pendFlag_q;

endmodule

// File: tb/tb_threshold_binarizer.sv
// ---------------------------------------------------------------------------
// tb_threshold_binarizer
//
// Directed bench for threshold_binarizer. Three instances share one input
// stream:
//   dutA  default parameters
//   dutB  3-bit counter, to exercise saturation
//   dutC  FG_ABOVE = 0, foreground means at or below the threshold
// Each check compares an output against a hand-computed expected value.
// ---------------------------------------------------------------------------
module tb_threshold_binarizer;

    logic       iClk = 1'b0;
    logic       iRst_n;
    logic [7:0] iGray;
    logic       iGrayValid;
    logic       iFvalid;
    logic [7:0] iThresh;
    logic       iThreshValid;

    logic        aBin, aBinValid, aFvalid, aCountValid, aPending;
    logic [7:0]  aGray, aActive;
    logic [19:0] aFgCount;

    logic        bBin, bBinValid, bFvalid, bCountValid, bPending;
    logic [7:0]  bGray, bActive;
    logic [2:0]  bFgCount;

    logic        cBin, cBinValid, cFvalid, cCountValid, cPending;
    logic [7:0]  cGray, cActive;
    logic [19:0] cFgCount;

    int compareCount = 0;
    int failCount    = 0;

    // The clock period is 10 time units.
    always #5 iClk = ~iClk;

    threshold_binarizer dutA (
        .iClk(iClk), .iRst_n(iRst_n), .iGray(iGray), .iGrayValid(iGrayValid),
        .iFvalid(iFvalid), .iThresh(iThresh), .iThreshValid(iThreshValid),
        .oBin(aBin), .oBinValid(aBinValid), .oFvalid(aFvalid), .oGray(aGray),
        .oFgCount(aFgCount), .oCountValid(aCountValid),
        .oActiveThresh(aActive), .oThreshPending(aPending)
    );

    threshold_binarizer #(.COUNT_W(3)) dutB (
        .iClk(iClk), .iRst_n(iRst_n), .iGray(iGray), .iGrayValid(iGrayValid),
        .iFvalid(iFvalid), .iThresh(iThresh), .iThreshValid(iThreshValid),
        .oBin(bBin), .oBinValid(bBinValid), .oFvalid(bFvalid), .oGray(bGray),
        .oFgCount(bFgCount), .oCountValid(bCountValid),
        .oActiveThresh(bActive), .oThreshPending(bPending)
    );

    threshold_binarizer #(.FG_ABOVE(1'b0)) dutC (
        .iClk(iClk), .iRst_n(iRst_n), .iGray(iGray), .iGrayValid(iGrayValid),
        .iFvalid(iFvalid), .iThresh(iThresh), .iThreshValid(iThreshValid),
        .oBin(cBin), .oBinValid(cBinValid), .oFvalid(cFvalid), .oGray(cGray),
        .oFgCount(cFgCount), .oCountValid(cCountValid),
        .oActiveThresh(cActive), .oThreshPending(cPending)
    );

    // Drive one cycle of inputs. Return 1 time unit after the consuming edge,
    // so that the registered outputs can be sampled away from the edge.
    task automatic applyStimulus(input logic [7:0] gray, input logic gv,
                                 input logic fv, input logic [7:0] thr,
                                 input logic tv);
        iGray        = gray;
        iGrayValid   = gv;
        iFvalid      = fv;
        iThresh      = thr;
        iThreshValid = tv;
        @(posedge iClk);
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Run the directed sequence.
    initial begin
        iRst_n = 1'b0;
        iGray = '0; iGrayValid = 1'b0; iFvalid = 1'b0;
        iThresh = '0; iThreshValid = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
        checkOutput("rst_active",   aActive,     128);
        checkOutput("rst_binvalid", aBinValid,   0);
        checkOutput("rst_bin",      aBin,        0);
        checkOutput("rst_fvalid",   aFvalid,     0);
        checkOutput("rst_fgcount",  aFgCount,    0);
        checkOutput("rst_cntvalid", aCountValid, 0);
        checkOutput("rst_pending",  aPending,    0);
        iRst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] frame of 4 pixels at default threshold 128");
        applyStimulus(100, 1, 1, 0, 0);
        applyStimulus(128, 1, 1, 0, 0);
        checkOutput("f1_p0_valid", aBinValid, 1);
        checkOutput("f1_p0_bin",   aBin,      0);
        checkOutput("f1_p0_gray",  aGray,     100);
        checkOutput("f1_p0_fval",  aFvalid,   1);
        applyStimulus(129, 1, 1, 0, 0);
        checkOutput("f1_p1_bin", aBin, 0);
        applyStimulus(255, 1, 1, 0, 0);
        checkOutput("f1_p2_bin", aBin, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("f1_p3_bin",  aBin,  1);
        checkOutput("f1_p3_gray", aGray, 255);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("f1_tail_valid",  aBinValid,   0);
        checkOutput("f1_tail_cntval", aCountValid, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("f1_cntvalid",  aCountValid, 1);
        checkOutput("f1_fgcount",   aFgCount,    2);
        checkOutput("f1_fgcount_c", cFgCount,    2);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("f1_cntvalid_drop", aCountValid, 0);
        checkOutput("f1_fgcount_hold",  aFgCount,    2);

        $display("[TB] threshold 50 arrives mid-frame");
        applyStimulus(60, 1, 1, 0, 0);
        applyStimulus(200, 1, 1, 50, 1);
        checkOutput("f2_pending", aPending, 1);
        checkOutput("f2_p0_bin",  aBin,     0);
        applyStimulus(100, 1, 1, 0, 0);
        checkOutput("f2_p1_bin", aBin,    1);
        checkOutput("f2_active", aActive, 128);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("f2_p2_bin_old_thr", aBin,     0);
        checkOutput("f2_pending_hold",   aPending, 1);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("f2_cntvalid", aCountValid, 1);
        checkOutput("f2_fgcount",  aFgCount,    1);

        $display("[TB] next frame adopts pending threshold 50");
        applyStimulus(51, 1, 1, 0, 0);
        checkOutput("f3_active",  aActive,  50);
        checkOutput("f3_pending", aPending, 0);
        applyStimulus(50, 1, 1, 0, 0);
        checkOutput("f3_p0_bin", aBin, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("f3_p1_bin",   aBin,      0);
        checkOutput("f3_p1_valid", aBinValid, 1);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] threshold 200 on the frame-start cycle");
        applyStimulus(199, 1, 1, 200, 1);
        checkOutput("f4_active",  aActive,  200);
        checkOutput("f4_pending", aPending, 0);
        applyStimulus(201, 1, 1, 0, 0);
        checkOutput("f4_p0_bin", aBin, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("f4_p1_bin",       aBin,     1);
        checkOutput("f4_pending_idle", aPending, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] two threshold pulses between frames, latest wins");
        applyStimulus(0, 0, 0, 10, 1);
        checkOutput("f5_pending", aPending, 1);
        applyStimulus(0, 0, 0, 20, 1);
        applyStimulus(15, 1, 1, 0, 0);
        checkOutput("f5_active", aActive, 20);
        applyStimulus(25, 1, 1, 0, 0);
        checkOutput("f5_p0_bin", aBin, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("f5_p1_bin", aBin, 1);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("f5_fgcount", aFgCount, 1);

        $display("[TB] saturation with a 3-bit counter");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(255, 1, 1, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("sat_cntvalid_b", bCountValid, 1);
        checkOutput("sat_fgcount_b",  bFgCount,    7);
        checkOutput("sat_fgcount_a",  aFgCount,    10);
        applyStimulus(255, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("sat_next_cntvalid_b", bCountValid, 1);
        checkOutput("sat_next_fgcount_b",  bFgCount,    1);

        $display("[TB] FG_ABOVE=0, pixel equal to threshold");
        applyStimulus(128, 1, 1, 128, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("eq_bin_c",    cBin,    1);
        checkOutput("eq_bin_a",    aBin,    0);
        checkOutput("eq_active_c", cActive, 128);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("eq_fgcount_c",      cFgCount,    1);
        checkOutput("zero_fg_cntvalid_a", aCountValid, 1);
        checkOutput("zero_fg_fgcount_a",  aFgCount,    0);

        $display("[TB] mid-frame reset, release while frame valid is high");
        applyStimulus(200, 1, 1, 0, 0);
        applyStimulus(200, 1, 1, 0, 0);
        checkOutput("mr_pre_valid", aBinValid, 1);
        iRst_n = 1'b0;
        #1;
        checkOutput("mr_valid_drop", aBinValid, 0);
        checkOutput("mr_fval_drop",  aFvalid,   0);
        checkOutput("mr_active",     aActive,   128);
        checkOutput("mr_fgcount",    aFgCount,  0);
        applyStimulus(200, 1, 1, 0, 0);
        iRst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(200, 1, 1, 0, 0);
            checkOutput("mr_skip_valid",    aBinValid,   0);
            checkOutput("mr_skip_cntvalid", aCountValid, 0);
        end
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("mr_no_cntvalid", aCountValid, 0);
        end

        $display("[TB] normal frame after skipped frame");
        applyStimulus(200, 1, 1, 0, 0);
        applyStimulus(100, 1, 1, 0, 0);
        checkOutput("post_p0_valid", aBinValid, 1);
        checkOutput("post_p0_bin",   aBin,      1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("post_p1_valid", aBinValid, 1);
        checkOutput("post_p1_bin",   aBin,      0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("post_cntvalid", aCountValid, 1);
        checkOutput("post_fgcount",  aFgCount,    1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/threshold_binarizer.md
Name: threshold_binarizer

Overview:
- Downstream consumer of the histogram/threshold stage. Takes the same grayscale pixel stream (gray, valid, frame-valid) plus the per-frame threshold and done pulse. Emits a 1-bit binarised pixel stream for the display/feature path.
- Latches a new threshold only at a frame boundary, so a frame is never split across two thresholds.
- Counts foreground pixels per frame and reports the total at frame end.

Parameters:
- DATA_W, 8, gray pixel width
- COUNT_W, 20, foreground counter width (same width as histogram bins)
- DEFAULT_THRESH, 128, active threshold after reset
- FG_ABOVE, 1, 1: foreground when gray > thresh; 0: foreground when gray <= thresh

Ports:
- iClk, in, 1, clock
- iRst_n, in, 1, asynchronous active-low reset
- iGray, in, DATA_W, input pixel
- iGrayValid, in, 1, pixel qualifier
- iFvalid, in, 1, frame valid (high for the whole frame)
- iThresh, in, DATA_W, threshold from the histogram stage
- iThreshValid, in, 1, one-cycle pulse: iThresh is valid (driven by the histogram stage's done pulse)
- oBin, out, 1, binarised pixel
- oBinValid, out, 1, oBin qualifier
- oFvalid, out, 1, iFvalid delayed to align with oBin
- oGray, out, DATA_W, iGray delayed to align with oBin
- oFgCount, out, COUNT_W, foreground count of the last completed frame
- oCountValid, out, 1, one-cycle pulse when oFgCount updates
- oActiveThresh, out, DATA_W, threshold applied to the current frame
- oThreshPending, out, 1, a new threshold is waiting for the next frame start

Behaviour:
- Reset (async, iRst_n=0):
  - All outputs 0, except oActiveThresh = DEFAULT_THRESH.
  - Pending flag 0, armed 0, counter 0, fvalid_prev 0.
- Frame start: rise = iFvalid & ~fvalid_prev.
  - On rise: armed <= 1.
  - On rise with pending=1: active <= pending value; pending flag cleared.
  - On rise with iThreshValid=1 in the same cycle: iThresh is applied directly to the frame that is starting; pending flag stays/ends 0.
- Threshold capture without rise: iThreshValid=1 sets pending value <= iThresh and pending flag <= 1. Latest pulse wins.
- The active threshold never changes while iFvalid is high.
- Arming after reset: armed clears on reset and sets on the first rise. If iFvalid is already high when reset releases, pixels are ignored (oBinValid=0, not counted) until the next rise.
- Pixel acceptance: a pixel is accepted when iGrayValid & iFvalid & (armed | rise). Pixels outside this condition produce oBinValid=0.
- Pipeline, stage 1 registers: gray, accept, iFvalid & armed_eff, and the effective threshold. The effective threshold is the new threshold on a rise cycle, otherwise active.
- Pipeline, stage 2:
  - oBin = FG_ABOVE ? (gray > thr) : (gray <= thr). Unsigned compare.
  - oBinValid = accept. oFvalid and oGray are aligned to oBin.
  - oBin is 0 whenever oBinValid = 0.
- Latency: exactly 2 cycles from input to oBin/oBinValid/oFvalid/oGray. Full throughput, one pixel per cycle, no backpressure.
- oActiveThresh updates the cycle after rise.
- Foreground counter:
  - Increments on oBinValid & oBin.
  - Saturates at 2^COUNT_W-1 (no wrap).
- Frame end: falling edge of oFvalid (stage-2 fvalid 1 to 0).
  - oFgCount <= counter, including any increment from that same cycle.
  - oCountValid pulses high for 1 cycle; counter clears to 0.
  - oFgCount holds until the next frame end.
- Frames with zero accepted pixels still report oFgCount=0 with an oCountValid pulse.
- Mid-frame reset: outputs drop immediately; no oCountValid is produced for the aborted frame.
- iFvalid glitch (1-cycle low mid-frame): treated as a frame end followed by a new frame start. No filtering.

Test Plan:
- Reset, then frame of 4 pixels {100,128,129,255}, DEFAULT_THRESH=128, FG_ABOVE=1 -> oBin {0,0,1,1} two cycles after each input; oFgCount=2 with oCountValid pulse after oFvalid falls.
- iThreshValid with iThresh=50 mid-frame -> current frame still uses 128; oThreshPending=1; next frame oActiveThresh=50, pixel 51 gives oBin=1, pixel 50 gives oBin=0; oThreshPending returns to 0.
- iThreshValid with iThresh=200 on the same cycle as iFvalid rise and first pixel 199 -> first pixel oBin=0, oActiveThresh=200, pending never set.
- Reset released while iFvalid high with valid pixels -> oBinValid stays 0 for that frame, no oCountValid; next frame is processed normally.
- Two iThreshValid pulses (10, then 20) between frames -> next frame uses 20.
- COUNT_W=3, frame of 10 pixels all 255 -> oFgCount=7 (saturated); next frame of 1 foreground pixel -> oFgCount=1. FG_ABOVE=0 with pixel 128 at thresh 128 -> oBin=1.
